// File: rtl/i2c_pkg.sv
// Shared types for the I2C slave front end: SDA drive modes and controller states.
package i2c_pkg;

    typedef enum logic [1:0] {
        RELEASE  = 2'b00,
        DRV_ACK  = 2'b01,
        DRV_NACK = 2'b10,
        TX_BIT   = 2'b11
    } sda_mode_t;

    // Legal states are encoded contiguously so that legality is a single compare.
    typedef enum logic [4:0] {
        IDLE       = 5'd0,
        ADDR_RX    = 5'd1,
        ADDR_CHK   = 5'd2,
        AACK_PREP  = 5'd3,
        AACK_DRIVE = 5'd4,
        AACK_HOLD  = 5'd5,
        WDATA_RX   = 5'd6,
        WDATA_CHK  = 5'd7,
        WACK_PREP  = 5'd8,
        WACK_DRIVE = 5'd9,
        WACK_HOLD  = 5'd10,
        LOAD       = 5'd11,
        SEND       = 5'd12,
        MACK_WAIT  = 5'd13,
        MACK_POP   = 5'd14,
        NACK_PREP  = 5'd15,
        NACK_DRIVE = 5'd16,
        NACK_HOLD  = 5'd17,
        WAIT_STOP  = 5'd18
    } slave_state_t;

    function automatic logic state_is_legal(input slave_state_t s);
        return s <= WAIT_STOP;
    endfunction

endpackage

// File: rtl/burst_counter.sv
// Per-transaction byte counter: synchronous clear, increment, saturation at MAX_BURST.
module burst_counter #(
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count,
    output logic             o_at_max
);

    localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && !o_at_max) begin
            r_count <= r_count + ONE;
        end
    end

    assign o_count  = r_count;
    assign o_at_max = (r_count == MAX_VAL);

endmodule

// File: rtl/i2c_slave_burst_ctrl.sv
// I2C slave protocol controller: addressed read/write bursts with FIFO flow control,
// repeated START and STOP abort from any state.
module i2c_slave_burst_ctrl
    import i2c_pkg::*;
#(
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_found,
    input  logic             stop_found,
    input  logic             byte_received,
    input  logic             ack_prep,
    input  logic             check_ack,
    input  logic             ack_done,
    input  logic             rw_mode,
    input  logic             address_match,
    input  logic             sda_in,
    input  logic             fifo_full,
    input  logic             fifo_empty,
    output logic             rx_enable,
    output logic             tx_enable,
    output logic             write_enable,
    output logic             read_enable,
    output logic             load_data,
    output logic [1:0]       sda_mode,
    output logic [CNT_W-1:0] byte_count,
    output logic             busy
);

    localparam logic [CNT_W:0] MAX_EXT = (CNT_W + 1)'(MAX_BURST);
    localparam logic [CNT_W:0] ONE_EXT = (CNT_W + 1)'(1);

    slave_state_t r_state;
    slave_state_t w_next;
    logic         r_rw_read;
    logic         w_write_en;
    logic         w_read_en;
    logic         w_at_max;
    logic         w_more_burst;
    sda_mode_t    w_sda;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_rw_read <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ADDR_CHK) begin
                r_rw_read <= rw_mode;
            end
        end
    end

    // Room for another read byte once the pop of this cycle has been counted.
    assign w_more_burst = (({1'b0, byte_count} + ONE_EXT) < MAX_EXT);

    // NOTE: every signal written here gets a default first so no path can infer a latch.
    always_comb begin
        w_next     = r_state;
        w_write_en = 1'b0;
        w_read_en  = 1'b0;
        case (r_state)
            IDLE:       w_next = IDLE;
            ADDR_RX:    if (byte_received) w_next = ADDR_CHK;
            ADDR_CHK: begin
                if (!address_match) begin
                    w_next = WAIT_STOP;
                end else if (rw_mode && fifo_empty) begin
                    w_next = NACK_PREP;
                end else begin
                    w_next = AACK_PREP;
                end
            end
            AACK_PREP:  if (ack_prep)  w_next = AACK_DRIVE;
            AACK_DRIVE: if (check_ack) w_next = AACK_HOLD;
            AACK_HOLD:  if (ack_done)  w_next = r_rw_read ? LOAD : WDATA_RX;
            WDATA_RX:   if (byte_received) w_next = WDATA_CHK;
            WDATA_CHK: begin
                if (!fifo_full && !w_at_max) begin
                    w_write_en = 1'b1;
                    w_next     = WACK_PREP;
                end else begin
                    w_next = NACK_PREP;
                end
            end
            WACK_PREP:  if (ack_prep)  w_next = WACK_DRIVE;
            WACK_DRIVE: if (check_ack) w_next = WACK_HOLD;
            WACK_HOLD:  if (ack_done)  w_next = WDATA_RX;
            LOAD:       w_next = SEND;
            SEND:       if (ack_prep)  w_next = MACK_WAIT;
            MACK_WAIT:  if (check_ack) w_next = sda_in ? WAIT_STOP : MACK_POP;
            MACK_POP: begin
                if (ack_done) begin
                    w_read_en = 1'b1;
                    w_next    = (w_more_burst && !fifo_empty) ? LOAD : WAIT_STOP;
                end
            end
            NACK_PREP:  if (ack_prep)  w_next = NACK_DRIVE;
            NACK_DRIVE: if (check_ack) w_next = NACK_HOLD;
            NACK_HOLD:  if (ack_done)  w_next = WAIT_STOP;
            WAIT_STOP:  w_next = WAIT_STOP;
            default:    w_next = IDLE;
        endcase

        // Bus conditions override the per-state flow and suppress any FIFO strobe.
        if (start_found) begin
            w_next     = ADDR_RX;
            w_write_en = 1'b0;
            w_read_en  = 1'b0;
        end else if (stop_found && r_state != IDLE) begin
            w_next     = IDLE;
            w_write_en = 1'b0;
            w_read_en  = 1'b0;
        end
    end

    always_comb begin
        rx_enable = 1'b0;
        tx_enable = 1'b0;
        load_data = 1'b0;
        w_sda     = RELEASE;
        case (r_state)
            ADDR_RX, WDATA_RX:                           rx_enable = 1'b1;
            AACK_DRIVE, AACK_HOLD, WACK_DRIVE, WACK_HOLD: w_sda = DRV_ACK;
            NACK_DRIVE, NACK_HOLD:                       w_sda = DRV_NACK;
            LOAD:                                        load_data = 1'b1;
            SEND: begin
                tx_enable = 1'b1;
                w_sda     = TX_BIT;
            end
            default: ;
        endcase
    end

    burst_counter #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) u_burst_counter (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (start_found),
        .i_inc    (w_write_en | w_read_en),
        .o_count  (byte_count),
        .o_at_max (w_at_max)
    );

    assign write_enable = w_write_en;
    assign read_enable  = w_read_en;
    assign sda_mode     = w_sda;
    assign busy         = (r_state != IDLE) && state_is_legal(r_state);

endmodule

// File: tb/tb_i2c_slave_burst_ctrl.sv
// Scoreboard bench: transaction tasks push predicted controller events, a negedge monitor
// pops and compares them against observed FIFO strobes, loads and ACK/NACK drives.
module tb_i2c_slave_burst_ctrl;

    localparam int MAX = 4;
    localparam int CW  = $clog2(MAX + 1);

    logic clk = 1'b0;
    logic rst;
    logic start_found, stop_found, byte_received, ack_prep, check_ack, ack_done;
    logic rw_mode, address_match, sda_in, fifo_full, fifo_empty;
    logic rx_enable, tx_enable, write_enable, read_enable, load_data, busy;
    logic [1:0]    sda_mode;
    logic [CW-1:0] byte_count;

    always #5 clk = ~clk;

    i2c_slave_burst_ctrl #(.MAX_BURST(MAX)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_found   (start_found),
        .stop_found    (stop_found),
        .byte_received (byte_received),
        .ack_prep      (ack_prep),
        .check_ack     (check_ack),
        .ack_done      (ack_done),
        .rw_mode       (rw_mode),
        .address_match (address_match),
        .sda_in        (sda_in),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .rx_enable     (rx_enable),
        .tx_enable     (tx_enable),
        .write_enable  (write_enable),
        .read_enable   (read_enable),
        .load_data     (load_data),
        .sda_mode      (sda_mode),
        .byte_count    (byte_count),
        .busy          (busy)
    );

    typedef enum int {EV_ACK = 0, EV_NACK = 1, EV_WE = 2, EV_RE = 3, EV_LOAD = 4} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       cnt;
    } ev_t;

    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic void expect_ev(input ev_kind_t k, input int c);
        ev_t e;
        e.kind = k;
        e.cnt  = c;
        exp_q.push_back(e);
    endfunction

    task automatic observe(input ev_kind_t k, input int c);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_event", int'(k), -1);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", int'(k), int'(e.kind));
            check("event_byte_count", c, e.cnt);
        end
    endtask

    // Monitor: every strobe cycle and every entry into an ACK/NACK drive is one event.
    logic [1:0] prev_sda = 2'b00;
    always @(negedge clk) begin
        if (rst) begin
            prev_sda = 2'b00;
        end else begin
            if (write_enable) observe(EV_WE, int'(byte_count));
            if (read_enable)  observe(EV_RE, int'(byte_count));
            if (load_data)    observe(EV_LOAD, int'(byte_count));
            if (sda_mode != prev_sda && sda_mode == 2'b01) observe(EV_ACK, int'(byte_count));
            if (sda_mode != prev_sda && sda_mode == 2'b10) observe(EV_NACK, int'(byte_count));
            prev_sda = sda_mode;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap();
        repeat ($urandom_range(2, 4)) begin
            sda_in = 1'($urandom);
            tick();
        end
    endtask

    task automatic pulse_start();
        start_found = 1'b1;
        tick();
        start_found = 1'b0;
    endtask

    task automatic pulse_stop();
        stop_found = 1'b1;
        tick();
        stop_found = 1'b0;
    endtask

    // Address byte; match and R/W are only valid for the strobe cycle and the one after.
    task automatic addr_byte(input bit match, input bit rd);
        byte_received = 1'b1;
        address_match = match;
        rw_mode       = rd;
        tick();
        byte_received = 1'b0;
        tick();
        address_match = 1'($urandom);
        rw_mode       = ~rd;
    endtask

    task automatic data_byte();
        gap();
        byte_received = 1'b1;
        tick();
        byte_received = 1'b0;
    endtask

    task automatic ack_phase(input bit sda_bit);
        gap();
        ack_prep = 1'b1;
        tick();
        ack_prep = 1'b0;
        gap();
        check_ack = 1'b1;
        sda_in    = sda_bit;
        tick();
        check_ack = 1'b0;
        gap();
        ack_done = 1'b1;
        tick();
        ack_done = 1'b0;
    endtask

    task automatic finish_txn(input string tag);
        pulse_stop();
        check({tag, "_busy_after_stop"}, int'(busy), 0);
        tick();
        check({tag, "_scoreboard_drained"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Master write of n bytes; the RX FIFO reports full from byte index full_from onward.
    task automatic run_write(input bit send_start, input bit match, input int n, input int full_from);
        int cnt     = 0;
        bit refused = 1'b0;
        if (match) begin
            expect_ev(EV_ACK, 0);
            for (int i = 0; i < n; i++) begin
                if (i >= full_from || cnt >= MAX) begin
                    expect_ev(EV_NACK, cnt);
                    refused = 1'b1;
                    break;
                end
                expect_ev(EV_WE, cnt);
                cnt++;
                expect_ev(EV_ACK, cnt);
            end
        end
        fifo_full  = (full_from == 0);
        fifo_empty = 1'($urandom);
        if (send_start) pulse_start();
        gap();
        addr_byte(match, 1'b0);
        ack_phase(1'($urandom));
        for (int i = 0; i < n; i++) begin
            fifo_full = (i >= full_from);
            data_byte();
            ack_phase(1'($urandom));
        end
        gap();
        check("wr_byte_count", int'(byte_count), cnt);
        check("wr_busy", int'(busy), 1);
        check("wr_rx_enable", int'(rx_enable), (match && !refused) ? 1 : 0);
        check("wr_sda_released", int'(sda_mode), 0);
        finish_txn("wr");
    endtask

    // Master read requesting nreq bytes (NACK on the last) from a TX FIFO holding `level`.
    // abort_at >= 0 issues a repeated START while byte abort_at is being shifted out.
    task automatic run_read(input bit match, input int level, input int nreq, input int abort_at);
        int cnt = 0;
        int lvl = level;
        if (match) begin
            if (lvl == 0) begin
                expect_ev(EV_NACK, 0);
            end else begin
                expect_ev(EV_ACK, 0);
                for (int j = 0; j < nreq; j++) begin
                    expect_ev(EV_LOAD, cnt);
                    if (j == abort_at || j == nreq - 1) break;
                    expect_ev(EV_RE, cnt);
                    cnt++;
                    lvl--;
                    if (cnt >= MAX || lvl == 0) break;
                end
            end
        end
        lvl        = level;
        fifo_full  = 1'($urandom);
        fifo_empty = (lvl == 0);
        pulse_start();
        gap();
        addr_byte(match, 1'b1);
        ack_phase(1'($urandom));
        for (int j = 0; j < nreq; j++) begin
            if (j == abort_at) begin
                gap();
                pulse_start();
                check("rs_rx_enable", int'(rx_enable), 1);
                check("rs_tx_enable", int'(tx_enable), 0);
                check("rs_byte_count", int'(byte_count), 0);
                check("rs_busy", int'(busy), 1);
                return;
            end
            gap();
            ack_prep = 1'b1;
            tick();
            ack_prep = 1'b0;
            gap();
            check_ack = 1'b1;
            sda_in    = (j == nreq - 1);
            tick();
            check_ack = 1'b0;
            gap();
            if (j != nreq - 1 && lvl > 0) lvl--;
            fifo_empty = (lvl == 0);
            ack_done   = 1'b1;
            tick();
            ack_done = 1'b0;
        end
        gap();
        check("rd_byte_count", int'(byte_count), cnt);
        check("rd_busy", int'(busy), 1);
        check("rd_tx_enable", int'(tx_enable), 0);
        check("rd_sda_released", int'(sda_mode), 0);
        finish_txn("rd");
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outputs"},
              int'({rx_enable, tx_enable, write_enable, read_enable, load_data, sda_mode, busy}), 0);
        check({tag, "_byte_count"}, int'(byte_count), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit m;
        rst = 1'b1;
        {start_found, stop_found, byte_received, ack_prep, check_ack, ack_done} = '0;
        {rw_mode, address_match, fifo_full, fifo_empty} = '0;
        sda_in = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();
        check_all_zero("post_reset");

        run_write(1'b1, 1'b1, 3, 99);       // plain 3-byte write
        run_read(1'b1, MAX + 2, MAX + 2, -1); // burst limit ends the read
        run_read(1'b1, 2, MAX + 2, -1);     // TX FIFO runs dry
        run_write(1'b1, 1'b1, 3, 1);        // RX FIFO fills after first byte
        run_write(1'b1, 1'b0, 2, 99);       // foreign address, write
        run_read(1'b0, 3, 2, -1);           // foreign address, read
        run_write(1'b1, 1'b1, MAX + 1, 99); // burst limit on write
        run_read(1'b1, 0, 2, -1);           // read with empty FIFO
        run_read(1'b1, 5, 2, -1);           // master NACKs the second byte

        run_read(1'b1, 5, 4, 1);            // repeated START while sending
        run_write(1'b0, 1'b1, 2, 99);

        // Reset while driving the data ACK.
        expect_ev(EV_ACK, 0);
        expect_ev(EV_WE, 0);
        expect_ev(EV_ACK, 1);
        fifo_full = 1'b0;
        pulse_start();
        gap();
        addr_byte(1'b1, 1'b0);
        ack_phase(1'b0);
        data_byte();
        gap();
        ack_prep = 1'b1;
        tick();
        ack_prep = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check_all_zero("async_reset");
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        check_all_zero("after_reset_release");
        check("reset_scoreboard_drained", exp_q.size(), 0);
        exp_q.delete();

        for (int t = 0; t < 40; t++) begin
            m = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 1) == 1)
                run_write(1'b1, m, $urandom_range(0, MAX + 2), $urandom_range(0, MAX + 3));
            else
                run_read(m, $urandom_range(0, MAX + 2), $urandom_range(1, MAX + 2), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
